alu_bist_ctrl: RTL

Built-in self-test sequencer that sits on the initiator side of the 8-bit ALU command interface. On `start` it drives every 4-bit command against pseudo-random operand pairs, waits for the ALU output to settle, and samples the 16-bit result each time. It compacts all results into a 16-bit MISR signature and compares the final signature against a programmed golden value. It replaces hand-written command sweeps for production self-test and regression of the ALU.

---
 rtl/alu_bist_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_bist_ctrl.sv
// alu_bist_ctrl: built-in self-test sequencer for the 8-bit ALU command port.
// Sweeps all 16 commands over LFSR-generated operand pairs for a number of
// passes, compacts every ALU result into a 16-bit MISR, and compares the final
// signature against a golden value.
module alu_bist_ctrl #(
  parameter logic [7:0]  SEED_A        = 8'd135,
  parameter logic [7:0]  SEED_B        = 8'd201,
  parameter int          NUM_PASSES    = 4,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] EXPECTED_SIG  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        oe,
  output logic [3:0]  command_out,
  output logic [7:0]  a_out,
  output logic [7:0]  b_out,
  input  logic [15:0] d_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [7:0] SEED_A_INIT = (SEED_A == 8'd0) ? 8'h01 : SEED_A;
  localparam logic [7:0] SEED_B_INIT = (SEED_B == 8'd0) ? 8'h01 : SEED_B;
  localparam logic [7:0] LAST_PASS   = 8'(NUM_PASSES - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cmd_p0;
  logic [3:0]  settle_cnt_p0;
  logic [7:0]  lfsr_a_p0, lfsr_b_p0;
  logic [7:0]  pass_cnt_p0;
  logic [15:0] sig_p0;
  logic        vld_p0;
  logic        start_ok;
  logic        cap_last;

  // CRC-16-CCITT style MISR step: shift, fold feedback, absorb the result.
  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] din);
    misr_step = ({sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000)) ^ din;
  endfunction

  // Maximal-length 8-bit Fibonacci LFSR (taps 7,5,4,3).
  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    lfsr_step = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  assign vld_p0    = (state == SETTLE) || (state == CAPTURE);
  // busy still high means DONE/IDLE was entered on the previous edge and the
  // registered outputs have not caught up yet; a start there is dropped.
  assign start_ok  = start && !vld_p0 && !busy;
  assign cap_last  = (cmd_p0 == 4'hF) && (pass_cnt_p0 == LAST_PASS);
  assign signature = sig_p0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; abort outranks capture.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_ok) state_nxt = SETTLE;
      SETTLE: begin
        if (abort)                            state_nxt = IDLE;
        else if (settle_cnt_p0 == SETTLE_LAST) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (abort)         state_nxt = IDLE;
        else if (cap_last) state_nxt = DONE;
        else               state_nxt = SETTLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: run state (command, operands, counters, MISR) ----
  // Run-state update: load on start, count settle cycles, absorb on capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_p0        <= 4'd0;
      settle_cnt_p0 <= 4'd0;
      lfsr_a_p0     <= SEED_A_INIT;
      lfsr_b_p0     <= SEED_B_INIT;
      pass_cnt_p0   <= 8'd0;
      sig_p0        <= 16'hFFFF;
    end else if (start_ok) begin
      cmd_p0        <= 4'd0;
      settle_cnt_p0 <= 4'd0;
      lfsr_a_p0     <= SEED_A_INIT;
      lfsr_b_p0     <= SEED_B_INIT;
      pass_cnt_p0   <= 8'd0;
      sig_p0        <= 16'hFFFF;
    end else if (state == SETTLE && !abort) begin
      settle_cnt_p0 <= settle_cnt_p0 + 4'd1;
    end else if (state == CAPTURE && !abort) begin
      sig_p0        <= misr_step(sig_p0, d_in);
      cmd_p0        <= cmd_p0 + 4'd1;
      settle_cnt_p0 <= 4'd0;
      if (cmd_p0 == 4'hF) begin
        lfsr_a_p0   <= lfsr_step(lfsr_a_p0);
        lfsr_b_p0   <= lfsr_step(lfsr_b_p0);
        pass_cnt_p0 <= pass_cnt_p0 + 8'd1;
      end
    end
  end

  // ---- stage p1: registered ALU drive and status outputs ----
  // Output registers follow the p0 state one cycle later; done/pass clear on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe          <= 1'b0;
      command_out <= 4'd0;
      a_out       <= 8'd0;
      b_out       <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      oe          <= vld_p0;
      command_out <= vld_p0 ? cmd_p0 : 4'd0;
      a_out       <= vld_p0 ? lfsr_a_p0 : 8'd0;
      b_out       <= vld_p0 ? lfsr_b_p0 : 8'd0;
      busy        <= vld_p0;
      if (start_ok) begin
        done <= 1'b0;
        pass <= 1'b0;
      end else begin
        done <= (state == DONE);
        pass <= (state == DONE) && (sig_p0 == EXPECTED_SIG);
      end
    end
  end

endmodule
